// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the unified memory.
//   if_*   : fetch-stage read port (req/addr in, rdata/ready/stall out)
//   dm_*   : memory-stage load/store port (req/we/addr/wdata in, rdata/ready/stall out)
//   mem_*  : single-ported memory macro side (en/we/addr/wdata out, rdata in)
// modport master is the arbiter's view; modport slave is the surrounding environment.
interface imem_dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          stall_if;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          stall_dm;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_dm,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one fixed-latency, single-ported memory between the fetch (IF)
// and memory (DM) stages. One access in flight at a time; round-robin on ties.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : imem_dmem_arbiter_if.master (IF port, DM port, memory macro side)
// All memory-side outputs, ready pulses and read data are registered; stalls are
// combinational from req and the registered ready.
module imem_dmem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  imem_dmem_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Winner of the current/most recent grant; doubles as the round-robin flag.
  logic          gnt_dm_q, gnt_dm_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          take_dm;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dm_d    = gnt_dm_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    take_dm     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.dm_req) begin
          // DM wins when alone, or on a tie if IF was granted last.
          take_dm     = bus.dm_req && (!bus.if_req || !gnt_dm_q);
          gnt_dm_d    = take_dm;
          mem_en_d    = 1'b1;
          mem_we_d    = take_dm && bus.dm_we;
          mem_addr_d  = take_dm ? bus.dm_addr : bus.if_addr;
          mem_wdata_d = take_dm ? bus.dm_wdata : mem_wdata_q;
          cnt_d       = CntW'(LAT);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (mem_we_q) begin
          dm_ready_d = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (gnt_dm_q) begin
            dm_rdata_d = bus.mem_rdata;
            dm_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gnt_dm_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_dm_q    <= gnt_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_dm  = bus.dm_req & ~dm_ready_q;

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

- Shares one single-ported, fixed-latency unified memory between two requesters in the pipelined core: the fetch stage (IF) and the memory stage (DM: lw/sw).
- Sequences each access: address issue, read-latency countdown, data capture and completion pulse.
- Raises per-port stall signals so the hazard logic freezes the waiting stage.
- Sits between the pipeline stage registers and the memory macro; all memory-side outputs are registered.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory read latency in cycles, from the mem_en cycle to mem_rdata valid (LAT ≥ 1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request, level, held until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- stall_if  out  1  if_req & ~if_ready
- dm_req  in  1  data request, level, held until dm_ready
- dm_we  in  1  1 = store (sw), 0 = load (lw)
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid when dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for DM
- stall_dm  out  1  dm_req & ~dm_ready
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid exactly LAT cycles after mem_en

## Operation
- Only one access is in flight at a time.
- States:
  - IDLE: arbitrate.
  - ISSUE: mem_en=1 for one cycle.
  - WAIT: down-counter, width clog2(LAT+1), loaded with LAT; capture mem_rdata when the counter reaches 0.
  - DONE: ready pulse, then return to IDLE.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last (round-robin).
  - A last-grant flag resets to IF, so DM wins the first tie.
- Grant latches the winner's addr/we/wdata into the mem_* registers. Inputs changing after the grant have no effect on the current access.
- Read: IDLE → ISSUE → WAIT (LAT cycles) → DONE. Captured data is held on the port's rdata until the next capture for that port.
- Write (DM with dm_we=1): IDLE → ISSUE → DONE. No WAIT state; IF is never a write.
- DONE: the granted port's ready=1 for exactly one cycle. Requests are ignored in DONE; re-arbitration occurs the following cycle in IDLE.
- A requester dropping its req mid-access does not abort the access. The memory cycle completes and ready still pulses.
- mem_we=1 only together with mem_en=1. mem_addr and mem_wdata hold their last values when idle.
- Reset, asynchronous, at any time:
  - state=IDLE, counter=0, last-grant=IF.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
  - Any in-flight read is abandoned; mem_rdata arriving after reset release is ignored.

## Timing
- Request sampled in IDLE at cycle 0 → mem_en=1 in cycle 1 → mem_rdata valid in cycle 1+LAT, captured at that edge → ready=1 in cycle 2+LAT.
- LAT=2: read completes in cycle 4, with the next grant possible in cycle 5. Write: mem_en in cycle 1, dm_ready in cycle 2, next grant in cycle 3.
- Stalls are combinational from req and the registered ready. A waiting port stalls from its req cycle through the cycle before its ready.
- Both requesting at cycle 0 after reset, LAT=2: DM ready in cycle 4, IF issued in cycle 6, IF ready in cycle 9.

## Test plan
- Single IF read, LAT=2, if_addr=0x40, memory returns 0x2008000A → mem_en in cycle 1 with addr 0x40; if_ready=1 and if_rdata=0x2008000A in cycle 4 only; stall_if=1 in cycles 0–3.
- DM store, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_en=mem_we=1 in cycle 1 with that addr/data; dm_ready in cycle 2; memory readback via IF at 0x100 returns 0xDEADBEEF.
- Both requesting continuously from reset → grants alternate DM, IF, DM, IF; no port is granted twice in a row while the other is pending.
- dm_addr changed to 0x200 in cycle 2 of a load from 0x100 → mem_addr stays 0x100 and dm_ready still in cycle 4.
- Reset asserted in the WAIT state of an IF read → all outputs 0 immediately; after release no if_ready pulse appears for the abandoned read, and a new request issues normally.
- LAT=1 and LAT=4 builds → read ready in cycles 3 and 6 respectively.
